// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered display data,
// hex/decimal glyphs, leading-zero blanking, per-digit decimal points and blinking.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_FRAMES   = 50,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic                    blink_q, blink_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_bm_q, pend_bm_d, act_bm_q, act_bm_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q;

  logic scan_wrap, frame_wrap;
  assign scan_wrap  = (div_q == DW'(SCAN_DIV - 1));
  assign frame_wrap = scan_wrap && (idx_q == IW'(NUM_DIGITS - 1));

  // upper_nz[k] is set when any active nibble at k or above is non-zero.
  logic [3:0] nib      [NUM_DIGITS];
  logic       upper_nz [NUM_DIGITS];
  logic       lz_blank [NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi] = act_val_q[gi*4 +: 4];
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign upper_nz[gi] = |nib[gi];
      end else begin : g_mid
        assign upper_nz[gi] = (|nib[gi]) | upper_nz[gi+1];
      end
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = blank_lz && !upper_nz[gi];
      end
    end
  endgenerate

  // Glyphs are held in active-low gfedcba form and flipped at the output if needed.
  function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = hex ? 7'b0001000 : 7'b1111111;
      4'hB: g = hex ? 7'b0000011 : 7'b1111111;
      4'hC: g = hex ? 7'b1000110 : 7'b1111111;
      4'hD: g = hex ? 7'b0100001 : 7'b1111111;
      4'hE: g = hex ? 7'b0000110 : 7'b1111111;
      default: g = hex ? 7'b0001110 : 7'b1111111;
    endcase
    return g;
  endfunction

  logic                  digit_off;
  logic                  dp_lit;
  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] onehot;

  always_comb begin
    digit_off = lz_blank[idx_q] || (blink_q && act_bm_q[idx_q]);
    seg_raw   = digit_off ? 7'h7F : glyph(nib[idx_q], hex_mode);
    dp_lit    = act_dp_q[idx_q] && !digit_off;
    seg_d     = (SEG_ACTIVE_LOW != 0) ? seg_raw : ~seg_raw;
    dp_d      = (SEG_ACTIVE_LOW != 0) ? ~dp_lit : dp_lit;
    onehot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    an_d      = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
  end

  always_comb begin
    div_d        = div_q + 1'b1;
    idx_d        = idx_q;
    frame_d      = frame_q;
    blink_d      = blink_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_bm_d    = pend_bm_q;
    pend_valid_d = pend_valid_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_bm_d     = act_bm_q;
    if (scan_wrap) begin
      div_d = '0;
      idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    end
    if (frame_wrap) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
      if (pend_valid_q) begin
        act_val_d    = pend_val_q;
        act_dp_d     = pend_dp_q;
        act_bm_d     = pend_bm_q;
        pend_valid_d = 1'b0;
      end
    end
    // A load on the boundary cycle lands in pending after the commit above.
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_bm_d    = blink_mask;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      blink_q      <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_bm_q    <= '0;
      pend_valid_q <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_bm_q     <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      fd_q         <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      blink_q      <= blink_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_bm_q    <= pend_bm_d;
      pend_valid_q <= pend_valid_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_bm_q     <= act_bm_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fd_q         <= frame_wrap;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4 cycles per digit, 2-frame blink, active-low.
module tb_seg_scan_driver;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;
  localparam logic [6:0] GX = 7'b1111111;

  logic        clk, rst_n, load, hex_mode, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in, blink_mask;
  logic [6:0]  seg;
  logic        dp, frame_done;
  logic [3:0]  an;

  seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blink_mask(blink_mask), .hex_mode(hex_mode), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpi;
    logic        hex;
    logic        lz;
    logic [27:0] eseg;  // {digit3, digit2, digit1, digit0}
    logic [3:0]  edp;   // active-low dp per digit
  } vec_t;

  vec_t vecs [10];
  int   n_chk, n_pass, nfr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (frame_done) nfr++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (frame_done) break;
    end
    chk("frame_done_wait", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic dsp_chk(input string nm, input int d, input logic [6:0] eseg, input logic edp);
    logic [3:0] ea;
    ea = ~(4'b0001 << d);
    chk(nm, {20'd0, seg, dp, an}, {20'd0, eseg, edp, ea});
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] bm);
    value = v; dp_in = d; blink_mask = bm; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  int n;
  logic phase;

  initial begin
    n_chk = 0; n_pass = 0; nfr = 0;
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blink_mask = '0;
    hex_mode = 1'b0; blank_lz = 1'b0;

    vecs[0] = '{16'h12A5, 4'b0010, 1'b1, 1'b0, {G1, G2, GA, G5}, 4'b1101};
    vecs[1] = '{16'h12A5, 4'b0010, 1'b0, 1'b0, {G1, G2, GX, G5}, 4'b1101};
    vecs[2] = '{16'h0007, 4'b0000, 1'b1, 1'b1, {GX, GX, GX, G7}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, 1'b1, {GX, GX, GX, G0}, 4'b1111};
    vecs[4] = '{16'h0000, 4'b0000, 1'b0, 1'b0, {G0, G0, G0, G0}, 4'b1111};
    vecs[5] = '{16'h0F0B, 4'b1111, 1'b1, 1'b1, {GX, GF, G0, GB}, 4'b1000};
    vecs[6] = '{16'h0800, 4'b0001, 1'b0, 1'b1, {GX, G8, G0, G0}, 4'b1110};
    vecs[7] = '{16'h9CE3, 4'b0000, 1'b1, 1'b1, {G9, GC, GE, G3}, 4'b1111};
    vecs[8] = '{16'h4D67, 4'b1010, 1'b1, 1'b0, {G4, GD, G6, G7}, 4'b0101};
    vecs[9] = '{16'hC000, 4'b0000, 1'b0, 1'b1, {GX, G0, G0, G0}, 4'b1111};

    // Reset held across clock edges, then release.
    ticks(3);
    chk("reset_outputs", {20'd0, seg, dp, an, frame_done}, {20'd0, GX, 1'b1, 4'b1111, 1'b0});
    rst_n = 1'b1; nfr = 0;
    tick();
    dsp_chk("release_digit0", 0, G0, 1'b1);
    ticks(3);
    dsp_chk("digit0_held", 0, G0, 1'b1);
    tick();
    dsp_chk("digit1_after_4", 1, G0, 1'b1);
    wait_fd(n);
    chk("first_frame_len", 5 + n, 16);
    wait_fd(n);
    chk("frame_period", n, 16);

    // Table: load right after a boundary, inspect the whole next frame.
    for (int v = 0; v < 10; v++) begin
      wait_fd(n);
      hex_mode = vecs[v].hex; blank_lz = vecs[v].lz;
      do_load(vecs[v].val, vecs[v].dpi, 4'b0000);
      wait_fd(n);
      tick();
      for (int d = 0; d < 4; d++) begin
        dsp_chk($sformatf("vec%0d_digit%0d", v, d), d, vecs[v].eseg[7*d +: 7], vecs[v].edp[d]);
        if (d < 3) ticks(4);
      end
    end

    // Blink on digit 0 only; phase follows frame count since reset.
    hex_mode = 1'b0; blank_lz = 1'b0;
    wait_fd(n);
    do_load(16'h1111, 4'b0000, 4'b0001);
    for (int f = 0; f < 4; f++) begin
      wait_fd(n);
      phase = ((nfr / 2) % 2) == 1;
      tick();
      dsp_chk($sformatf("blink_f%0d_digit0", f), 0, phase ? GX : G1, 1'b1);
      ticks(12);
      dsp_chk($sformatf("blink_f%0d_digit3", f), 3, G1, 1'b1);
    end

    // Two loads mid-frame: current frame untouched, next shows the last one.
    do_load(16'h3333, 4'b0000, 4'b0000);
    wait_fd(n);
    ticks(4);
    do_load(16'h1111, 4'b0000, 4'b0000);
    do_load(16'h2222, 4'b0000, 4'b0000);
    ticks(3);
    dsp_chk("midload_digit2_old", 2, G3, 1'b1);
    ticks(4);
    dsp_chk("midload_digit3_old", 3, G3, 1'b1);
    wait_fd(n);
    chk("midload_frame_len", n, 3);
    tick();
    dsp_chk("midload_digit0_new", 0, G2, 1'b1);
    ticks(4);
    dsp_chk("midload_digit1_new", 1, G2, 1'b1);

    // Load on the exact boundary cycle commits one frame later.
    wait_fd(n);
    ticks(15);
    value = 16'h4444; load = 1'b1;
    tick();
    load = 1'b0;
    chk("boundary_load_fd", {31'd0, frame_done}, 32'd1);
    tick();
    dsp_chk("boundary_load_not_yet", 0, G2, 1'b1);
    wait_fd(n);
    tick();
    dsp_chk("boundary_load_committed", 0, G4, 1'b1);

    // Asynchronous reset mid-digit.
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_now", {20'd0, seg, dp, an, frame_done}, {20'd0, GX, 1'b1, 4'b1111, 1'b0});
    @(negedge clk);
    chk("async_reset_hold", {20'd0, seg, dp, an, frame_done}, {20'd0, GX, 1'b1, 4'b1111, 1'b0});
    rst_n = 1'b1; nfr = 0;
    tick();
    dsp_chk("after_reset_digit0_cleared", 0, G0, 1'b1);
    wait_fd(n);
    chk("after_reset_frame_len", 1 + n, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed N-digit seven-segment display driver. It is the successor to the single-digit BCD-to-segment decoder and is parametrised in digit count, scan rate and output polarity. It adds a hex mode, leading-zero blanking, per-digit decimal points and per-digit blinking. Display data is double-buffered and committed only at frame boundaries, so the display never shows a torn value. It sits between the clock/counter logic and the board's shared segment bus and digit-select pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (≥2); digit 0 is least significant.
SCAN_DIV, 1000, clock cycles each digit stays selected (≥2).
BLINK_FRAMES, 50, full scan frames per blink half-period (≥1).
SEG_ACTIVE_LOW, 1, 1 means seg/dp are driven 0 = lit.
AN_ACTIVE_LOW, 1, 1 means the selected an bit is 0.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
load  in  1  single-cycle strobe; captures value/dp_in/blink_mask into the pending buffer
value  in  4*NUM_DIGITS  nibble k = digit k
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blink_mask  in  NUM_DIGITS  1 = digit blinks
hex_mode  in  1  1 = nibbles 10-15 show A,b,C,d,E,F; 0 = show blank
blank_lz  in  1  1 = suppress leading zeros
seg  out  7  segments, bit order {g,f,e,d,c,b,a}
dp  out  1  decimal point of the selected digit
an  out  NUM_DIGITS  one-hot digit select
frame_done  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (async assert, rst_n=0):
  - div_cnt=0, idx=0, frame_cnt=0, blink_phase=0.
  - Pending and active buffers cleared to 0; pend_valid=0.
  - Outputs: all segments off, dp off, all an inactive, frame_done=0.
- Reset deassert mid-scan is legal; scanning restarts at digit 0 from a clean state.
- div_cnt counts 0..SCAN_DIV-1 and then wraps. At div_cnt==SCAN_DIV-1, idx advances by 1 and wraps NUM_DIGITS-1 → 0.
- Frame boundary is the cycle where idx wraps NUM_DIGITS-1 → 0. On that cycle:
  - frame_done=1 on the next registered output.
  - If pend_valid, pending is copied to active and pend_valid is cleared.
  - frame_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- load captures the inputs into pending and sets pend_valid. A later load before the boundary overwrites pending (last wins).
- If load coincides with a boundary, the new data goes to pending, is not committed that boundary, and commits at the next one.
- Outputs are registered, with 1 cycle latency from idx/active state. an selects idx.
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked if all active nibbles k..NUM_DIGITS-1 are 0.
  - Digit 0 is never blanked by this rule.
  - A blanked digit also has dp forced off.
- Blink: when blink_phase=1 and active blink_mask[k]=1, digit k shows segments off and dp off. an still cycles normally.
- Glyphs in gfedcba form, active-low (inverted when SEG_ACTIVE_LOW=0):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- A nibble >9 with hex_mode=0 is shown as blank.
- hex_mode and blank_lz are live (not buffered) and take effect on the next output register update.

Test Plan:
Use NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, active-low polarity throughout.
- Reset → seg=1111111, dp=1, an=1111, frame_done=0. Release → 1 cycle later an=1110 with seg=1000000 (active=0, digit 0); an advances every 4 cycles; frame_done pulses every 16 cycles.
- load value=16'h12A5, dp_in=0010, hex_mode=1 → after the next frame_done, digits 3..0 show 1111001, 0100100, 0001000, 0010010; dp=0 only while an=1101.
- Same value with hex_mode=0 → digit 1 shows 1111111.
- value=16'h0007, blank_lz=1 → digits 3,2,1 blank and digit 0 = 1111000. value=16'h0000 → only digit 0 lit, showing 1000000.
- blink_mask=0001, value=16'h1111 → digit 0 is lit for 2 frames and blank for 2 frames, repeating; digits 3..1 are always lit.
- Two loads mid-frame (16'h1111, then 16'h2222) → the frame in progress is unchanged and the next frame shows all 2s.
- Load on the exact boundary cycle → committed one frame later.
- Assert rst_n=0 mid-digit → outputs go to reset values immediately without waiting for clk.
